cpu_run_ctrl: RTL and testbench

//  Run/step sequencer for the pipelined CPU on the board. Takes raw push-buttons and a speed

---
 rtl/cpu_run_ctrl_pkg.sv | 21 ++
 rtl/cpu_run_ctrl_btn_debounce.sv | 66 ++++++
 rtl/cpu_run_ctrl.sv | 131 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cpu_run_ctrl_pkg                                      |
// | Brief    : State encodings shared by the CPU run/step sequencer.  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package cpu_run_ctrl_pkg;

  localparam int STATE_W = 3;

  // Encodings are visible on the LED port, so they are fixed values.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PAUSE = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_btn_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : btn_debounce                                          |
// | Brief    : 2-FF synchroniser plus stability-window debouncer;    |
// |            press is a one-cycle pulse on each debounced rise.    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
import cpu_run_ctrl_pkg::*;

module btn_debounce #(
  parameter int DEB_BITS = 20
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  logic                sync1_q;
  logic                sync2_q;
  logic                level_q;
  logic                level_d;
  logic                press_q;
  logic                press_d;
  logic [DEB_BITS-1:0] cnt_q;
  logic [DEB_BITS-1:0] cnt_d;

  // cnt_q counts consecutive cycles the synced input disagrees with level_q;
  // the level flips on the 2**DEB_BITS-th such cycle.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cpu_run_ctrl                                          |
// | Brief    : Run/step sequencer driving pcpu enable/start/ce from  |
// |            debounced buttons, with a rate divider and step count.|
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
import cpu_run_ctrl_pkg::*;

module cpu_run_ctrl #(
  parameter int DEB_BITS = 20,
  parameter int DIV_BITS = 21
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_step,
  input  logic        btn_halt,
  input  logic [1:0]  speed,
  input  logic        cpu_halt,
  output logic        cpu_ce,
  output logic        cpu_start,
  output logic        cpu_enable,
  output logic [2:0]  state,
  output logic [15:0] step_count
);

  logic w_press_start;
  logic w_press_step;
  logic w_press_halt;
  logic w_unused_start_level;
  logic w_unused_step_level;
  logic w_unused_halt_level;

  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_start (
    .CLK     (CLK),
    .reset   (reset),
    .btn_raw (btn_start),
    .level   (w_unused_start_level),
    .press   (w_press_start)
  );

  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_step (
    .CLK     (CLK),
    .reset   (reset),
    .btn_raw (btn_step),
    .level   (w_unused_step_level),
    .press   (w_press_step)
  );

  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_halt (
    .CLK     (CLK),
    .reset   (reset),
    .btn_raw (btn_halt),
    .level   (w_unused_halt_level),
    .press   (w_press_halt)
  );

  // Free-running divider; the mask keeps the low DIV_BITS-4*speed bits.
  logic [DIV_BITS-1:0] div_q;
  logic [DIV_BITS-1:0] w_tick_mask;
  logic                w_tick;

  assign w_tick_mask = {DIV_BITS{1'b1}} >> {speed, 2'b00};
  assign w_tick      = &(div_q | ~w_tick_mask);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_q + 1'b1;
  end

  state_e      state_q;
  state_e      state_d;
  logic        cpu_ce_q;
  logic        cpu_ce_d;
  logic        cpu_start_q;
  logic        cpu_start_d;
  logic        cpu_enable_q;
  logic        cpu_enable_d;
  logic [15:0] step_count_q;
  logic [15:0] step_count_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_press_start) state_d = S_LOAD;
      S_LOAD:  state_d = S_PAUSE;
      S_PAUSE: begin
        if (w_press_start)     state_d = S_RUN;
        else if (w_press_step) state_d = S_STEP;
      end
      S_STEP:  state_d = S_PAUSE;
      S_RUN:   if (w_press_halt || cpu_halt) state_d = S_PAUSE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered outputs
    // line up with the registered state; a halting RUN cycle drops its tick.
    cpu_ce_d     = (state_d == S_LOAD) || (state_d == S_STEP) ||
                   ((state_q == S_RUN) && (state_d == S_RUN) && w_tick);
    cpu_start_d  = (state_d == S_LOAD);
    cpu_enable_d = (state_d != S_IDLE);

    step_count_d = step_count_q;
    if (cpu_ce_q && (step_count_q != 16'hFFFF)) step_count_d = step_count_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cpu_ce_q     <= 1'b0;
      cpu_start_q  <= 1'b0;
      cpu_enable_q <= 1'b0;
      step_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cpu_ce_q     <= cpu_ce_d;
      cpu_start_q  <= cpu_start_d;
      cpu_enable_q <= cpu_enable_d;
      step_count_q <= step_count_d;
    end
  end

  assign cpu_ce     = cpu_ce_q;
  assign cpu_start  = cpu_start_q;
  assign cpu_enable = cpu_enable_q;
  assign state      = state_q;
  assign step_count = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_cpu_run_ctrl                                       |
// | Brief    : Directed self-checking bench for cpu_run_ctrl.        |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_cpu_run_ctrl;

  logic        CLK;
  logic        reset;
  logic        btn_start;
  logic        btn_step;
  logic        btn_halt;
  logic [1:0]  speed;
  logic        cpu_halt;
  logic        cpu_ce;
  logic        cpu_start;
  logic        cpu_enable;
  logic [2:0]  state;
  logic [15:0] step_count;

  int checks      = 0;
  int errors      = 0;
  int ce_seen     = 0;
  int ce_consec   = 0;
  int start_seen  = 0;
  int saw_load    = 0;
  logic prev_ce   = 1'b0;
  int gap;

  cpu_run_ctrl #(.DEB_BITS(3), .DIV_BITS(13)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_step   (btn_step),
    .btn_halt   (btn_halt),
    .speed      (speed),
    .cpu_halt   (cpu_halt),
    .cpu_ce     (cpu_ce),
    .cpu_start  (cpu_start),
    .cpu_enable (cpu_enable),
    .state      (state),
    .step_count (step_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and update the output monitors.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (cpu_ce) begin
        ce_seen++;
        if (prev_ce) ce_consec++;
      end
      prev_ce = cpu_ce;
      if (cpu_start) start_seen++;
      if (state == 3'd1) saw_load = 1;
    end
  endtask

  task automatic clr();
    ce_seen = 0; ce_consec = 0; start_seen = 0; saw_load = 0;
  endtask

  // Waits for a cpu_ce pulse, then returns cycles to the next one (-1 on timeout).
  task automatic measure_gap(output int g);
    int n;
    g = -1;
    n = 0;
    while (cpu_ce !== 1'b1 && n < 9000) begin cyc(1); n++; end
    if (cpu_ce === 1'b1) begin
      n = 0;
      cyc(1);
      while (cpu_ce !== 1'b1 && n < 9000) begin cyc(1); n++; end
      if (cpu_ce === 1'b1) g = n + 1;
    end
  endtask

  task automatic push_start();
    btn_start = 1'b1; cyc(20);
    btn_start = 1'b0; cyc(20);
  endtask

  initial begin
    reset = 1'b0; btn_start = 1'b0; btn_step = 1'b0; btn_halt = 1'b0;
    speed = 2'd0; cpu_halt = 1'b0;
    cyc(3);
    check("rst_state", state, 3'd0);
    check("rst_ce", cpu_ce, 1'b0);
    check("rst_start", cpu_start, 1'b0);
    check("rst_enable", cpu_enable, 1'b0);
    check("rst_count", step_count, 16'd0);
    reset = 1'b1;
    cyc(5);

    // Bouncing start: one press only, IDLE -> LOAD -> PAUSE.
    clr();
    btn_start = 1'b1; cyc(1);
    btn_start = 1'b0; cyc(1);
    btn_start = 1'b1; cyc(1);
    btn_start = 1'b0; cyc(1);
    btn_start = 1'b1; cyc(20);
    btn_start = 1'b0; cyc(20);
    check("deb_start_pulses", start_seen, 1);
    check("deb_ce_pulses", ce_seen, 1);
    check("deb_saw_load", saw_load, 1);
    check("deb_state", state, 3'd2);
    check("deb_enable", cpu_enable, 1'b1);
    check("deb_count", step_count, 16'd1);

    // Three single steps from PAUSE.
    clr();
    for (int k = 0; k < 3; k++) begin
      btn_step = 1'b1; cyc(20);
      btn_step = 1'b0; cyc(20);
      check("step_state", state, 3'd2);
    end
    check("step_ce_pulses", ce_seen, 3);
    check("step_consec", ce_consec, 0);
    check("step_count", step_count, 16'd4);

    // Run at speed 3: tick period 2.
    speed = 2'd3;
    push_start();
    check("run_state", state, 3'd3);
    clr();
    cyc(20);
    check("run_ce_in_20", ce_seen, 10);
    check("run_consec", ce_consec, 0);
    measure_gap(gap);
    check("run_gap_spd3", gap, 2);
    speed = 2'd0;
    measure_gap(gap);
    measure_gap(gap);
    check("run_gap_spd0", gap, 8192);

    // cpu_halt on a tick cycle: the tick is dropped and the FSM pauses.
    speed = 2'd3;
    measure_gap(gap);
    cyc(1);
    cpu_halt = 1'b1;
    cyc(1);
    cpu_halt = 1'b0;
    check("halt_tick_ce", cpu_ce, 1'b0);
    check("halt_tick_state", state, 3'd2);
    clr();
    cyc(10);
    check("halt_no_ce", ce_seen, 0);
    cpu_halt = 1'b1; cyc(10); cpu_halt = 1'b0;
    check("halt_ignored_pause", state, 3'd2);

    // Simultaneous halt and start in RUN: halt wins.
    push_start();
    check("resume_state", state, 3'd3);
    btn_halt = 1'b1; btn_start = 1'b1; cyc(20);
    check("halt_start_state", state, 3'd2);
    btn_halt = 1'b0; btn_start = 1'b0; cyc(20);
    clr();
    cyc(10);
    check("halt_start_settled", state, 3'd2);
    check("halt_start_no_ce", ce_seen, 0);

    // Step counter saturation.
    force dut.step_count_q = 16'hFFFE;
    cyc(2);
    release dut.step_count_q;
    cyc(1);
    check("sat_preset", step_count, 16'hFFFE);
    btn_step = 1'b1; cyc(20); btn_step = 1'b0; cyc(20);
    check("sat_first", step_count, 16'hFFFF);
    for (int k = 0; k < 2; k++) begin
      btn_step = 1'b1; cyc(20);
      btn_step = 1'b0; cyc(20);
    end
    check("sat_hold", step_count, 16'hFFFF);

    // Asynchronous reset in the middle of RUN.
    push_start();
    check("prereset_state", state, 3'd3);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    check("mid_rst_state", state, 3'd0);
    check("mid_rst_ce", cpu_ce, 1'b0);
    check("mid_rst_start", cpu_start, 1'b0);
    check("mid_rst_enable", cpu_enable, 1'b0);
    check("mid_rst_count", step_count, 16'd0);
    cyc(2);
    reset = 1'b1;
    clr();
    cyc(30);
    check("post_rst_no_ce", ce_seen, 0);
    check("post_rst_state", state, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
